// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory port arbiter.
//   arb_state_e : arbiter FSM states
//   grant_e     : owner of the most recent memory grant
//   SZ_*        : RISC-V funct3 load/store width/sign codes (passed to memory)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_WAIT = 2'd1,
        I_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_DATA  = 1'b0,
        GRANT_FETCH = 1'b1
    } grant_e;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: cycle counter that flags a hung memory access.
//   clock, rst : clock, asynchronous active-low reset
//   clr        : restart count at 0 (new grant)
//   en         : an access is outstanding; count advances each cycle
//   expired    : combinational pulse in the cycle the count sits at TIMEOUT-1
//                while enabled, i.e. the last cycle an ack is still accepted
module mem_arb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    assign expired = en && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF-stage fetches and MEM-stage loads/stores onto
// one single-port unified memory.
//   clock, rst        : clock, asynchronous active-low reset
//   if_req/if_addr    : fetch request (held until if_valid) and PC
//   if_rdata/if_valid : fetched instruction, one-cycle completion pulse
//   if_stall          : fetch must hold (request pending, not completing)
//   d_rd/d_wr/d_addr/d_wdata/d_size : load/store request (rd+wr = store)
//   d_rdata/d_valid/d_stall         : load data, completion pulse, hold
//   err               : one-cycle pulse when an access is abandoned
//   mem_*             : registered memory request side; mem_en is a one-cycle
//                       strobe, mem_ack/mem_rdata complete the access
// Optional: define MEM_ARB_PERF_CNT_EN to add saturating 32-bit stall counters
// fetch_stall_cnt / data_stall_cnt.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_size,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_size,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_stall_cnt,
    output logic [31:0]       data_stall_cnt
`endif
);

    arb_state_e state, state_nx;
    grant_e     last_grant;
    logic       cur_store;
    logic       d_req;
    logic       grant_d, grant_f;
    logic       wd_en, wd_expired;
    logic       finish;

    assign d_req    = d_rd | d_wr;
    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;
    assign finish   = mem_ack | wd_expired;

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clock   (clock),
        .rst     (rst),
        .clr     (grant_d | grant_f),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Grants are held off while a valid pulse is out so the requester gets a
    // cycle to move on before the port is handed out again. On contention the
    // side that did not win last time goes first.
    always_comb begin
        state_nx = state;
        grant_d  = 1'b0;
        grant_f  = 1'b0;
        wd_en    = 1'b0;
        case (state)
            IDLE: begin
                if (!(if_valid || d_valid)) begin
                    if (d_req && (!if_req || last_grant == GRANT_FETCH)) begin
                        grant_d  = 1'b1;
                        state_nx = D_WAIT;
                    end else if (if_req) begin
                        grant_f  = 1'b1;
                        state_nx = I_WAIT;
                    end
                end
            end
            D_WAIT, I_WAIT: begin
                wd_en = 1'b1;
                if (finish) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_size   <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            err        <= 1'b0;
            cur_store  <= 1'b0;
            last_grant <= GRANT_DATA;
        end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            err      <= 1'b0;

            if (grant_d) begin
                mem_en     <= 1'b1;
                mem_we     <= d_wr;
                mem_addr   <= d_addr;
                mem_wdata  <= d_wdata;
                mem_size   <= d_size;
                cur_store  <= d_wr;
                last_grant <= GRANT_DATA;
            end else if (grant_f) begin
                mem_en     <= 1'b1;
                mem_addr   <= if_addr;
                mem_size   <= SZ_W;
                last_grant <= GRANT_FETCH;
            end

            // An abandoned access still completes toward its requester, with
            // zeroed data, so the pipeline never waits forever.
            if (state == I_WAIT && finish) begin
                if_valid <= 1'b1;
                err      <= ~mem_ack;
                if_rdata <= mem_ack ? mem_rdata : '0;
            end
            if (state == D_WAIT && finish) begin
                d_valid <= 1'b1;
                err     <= ~mem_ack;
                if (!cur_store) d_rdata <= mem_ack ? mem_rdata : '0;
            end
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            fetch_stall_cnt <= '0;
            data_stall_cnt  <= '0;
        end else begin
            if (if_stall && fetch_stall_cnt != 32'hFFFF_FFFF) fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
            if (d_stall && data_stall_cnt != 32'hFFFF_FFFF)   data_stall_cnt  <= data_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
